// File: rtl/bus_xfer_unit.sv
// bus_xfer_unit: registered source-bus mux with idle hold, conflict detection and fixed/round-robin grant.
module bus_xfer_unit #(
  parameter int WIDTH = 32,
  parameter int NSRC = 24,
  parameter bit HOLD_IDLE = 1'b1,
  parameter bit ARB_MODE = 1'b0,
  localparam int SEL_W = $clog2(NSRC)
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic [NSRC-1:0]       src_out,
  input  logic                  conflict_clr,
  output logic [WIDTH-1:0]      bus_out,
  output logic                  bus_valid,
  output logic [SEL_W-1:0]      bus_sel,
  output logic                  conflict,
  output logic [7:0]            conflict_cnt,
  output logic [15:0]           xfer_cnt
);
  if (NSRC < 2 || WIDTH < 1) begin : g_bad_size
    $error("bus_xfer_unit needs NSRC >= 2 and WIDTH >= 1");
  end
  logic [WIDTH-1:0] bus_out_q;
  logic             bus_valid_q, conflict_q, conflict_d, any_d, multi_d;
  logic [SEL_W-1:0] bus_sel_q, rp_q, grant_d;
  logic [7:0]       conflict_cnt_q, conflict_cnt_d;
  logic [15:0]      xfer_cnt_q;
  int               idx;
  // Descending scans so the earliest candidate in search order is the last write.
  always_comb begin
    grant_d = '0;
    idx = 0;
    if (!ARB_MODE) begin
      for (int i = NSRC - 1; i >= 0; i--)
        if (src_out[i]) grant_d = SEL_W'(i);
    end else begin
      for (int k = NSRC; k >= 1; k--) begin
        idx = (int'(rp_q) + k) % NSRC;
        if (src_out[idx]) grant_d = SEL_W'(idx);
      end
    end
    any_d = |src_out;
    multi_d = |(src_out & (src_out - 1'b1));
    conflict_d = multi_d | (conflict_q & ~conflict_clr);
    conflict_cnt_d = multi_d ? (conflict_clr ? 8'd1 : conflict_cnt_q + {7'd0, conflict_cnt_q != 8'hff})
                             : (conflict_clr ? 8'd0 : conflict_cnt_q);
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      bus_out_q <= '0;
      bus_valid_q <= 1'b0;
      bus_sel_q <= '0;
      conflict_q <= 1'b0;
      conflict_cnt_q <= '0;
      xfer_cnt_q <= '0;
      rp_q <= SEL_W'(NSRC - 1);
    end else begin
      bus_valid_q <= any_d;
      conflict_q <= conflict_d;
      conflict_cnt_q <= conflict_cnt_d;
      if (any_d) begin
        bus_out_q <= src_data[int'(grant_d)*WIDTH +: WIDTH];
        bus_sel_q <= grant_d;
        rp_q <= grant_d;
      end else if (!HOLD_IDLE) begin
        bus_out_q <= '0;
      end
      if (any_d && !multi_d) xfer_cnt_q <= xfer_cnt_q + 16'd1;
    end
  end
  assign bus_out = bus_out_q;
  assign bus_valid = bus_valid_q;
  assign bus_sel = bus_sel_q;
  assign conflict = conflict_q;
  assign conflict_cnt = conflict_cnt_q;
  assign xfer_cnt = xfer_cnt_q;
endmodule

// File: tb/tb_bus_xfer_unit.sv
// tb_bus_xfer_unit: two configurations (hold/fixed and clear/round-robin) driven together against a behavioural model.
module tb_bus_xfer_unit;
  localparam int W = 32;
  localparam int N = 24;
  logic clk = 1'b0;
  logic clr, conflict_clr;
  logic [N*W-1:0] src_data;
  logic [N-1:0] src_out;
  logic [W-1:0] bo0, bo1;
  logic bv0, bv1, cf0, cf1;
  logic [4:0] bs0, bs1;
  logic [7:0] cc0, cc1;
  logic [15:0] xc0, xc1;
  int tests = 0;
  int failed = 0;
  logic [W-1:0] data [N];
  logic [W-1:0] m_bus [2];
  logic m_valid [2];
  int m_sel [2];
  logic m_conf [2];
  int m_cc [2];
  int m_xc [2];
  int m_rp [2];
  bit hold [2] = '{1'b1, 1'b0};
  bit arb [2] = '{1'b0, 1'b1};

  always #5 clk = ~clk;

  bus_xfer_unit #(.WIDTH(W), .NSRC(N), .HOLD_IDLE(1'b1), .ARB_MODE(1'b0)) dut0 (
    .clk(clk), .clr(clr), .src_data(src_data), .src_out(src_out), .conflict_clr(conflict_clr),
    .bus_out(bo0), .bus_valid(bv0), .bus_sel(bs0), .conflict(cf0), .conflict_cnt(cc0), .xfer_cnt(xc0));
  bus_xfer_unit #(.WIDTH(W), .NSRC(N), .HOLD_IDLE(1'b0), .ARB_MODE(1'b1)) dut1 (
    .clk(clk), .clr(clr), .src_data(src_data), .src_out(src_out), .conflict_clr(conflict_clr),
    .bus_out(bo1), .bus_valid(bv1), .bus_sel(bs1), .conflict(cf1), .conflict_cnt(cc1), .xfer_cnt(xc1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [N-1:0] so, input logic c, input logic cc);
    int n, g;
    n = $countones(so);
    for (int d = 0; d < 2; d++) begin
      if (c) begin
        m_bus[d] = '0; m_valid[d] = 0; m_sel[d] = 0; m_conf[d] = 0; m_cc[d] = 0; m_xc[d] = 0; m_rp[d] = N - 1;
      end else begin
        if (n == 0) begin
          m_valid[d] = 0;
          if (!hold[d]) m_bus[d] = '0;
        end else begin
          g = -1;
          for (int k = 0; k < N && g < 0; k++) begin
            int cand;
            cand = arb[d] ? (m_rp[d] + 1 + k) % N : k;
            if (so[cand]) g = cand;
          end
          m_bus[d] = data[g]; m_sel[d] = g; m_valid[d] = 1; m_rp[d] = g;
          if (n == 1) m_xc[d] = (m_xc[d] + 1) % 65536;
        end
        if (n > 1) begin
          m_conf[d] = 1;
          m_cc[d] = cc ? 1 : (m_cc[d] < 255 ? m_cc[d] + 1 : 255);
        end else if (cc) begin
          m_conf[d] = 0; m_cc[d] = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("bus_out0", bo0, m_bus[0]);   chk("bus_out1", bo1, m_bus[1]);
    chk("valid0", 32'(bv0), 32'(m_valid[0])); chk("valid1", 32'(bv1), 32'(m_valid[1]));
    chk("sel0", 32'(bs0), m_sel[0]);  chk("sel1", 32'(bs1), m_sel[1]);
    chk("conf0", 32'(cf0), 32'(m_conf[0])); chk("conf1", 32'(cf1), 32'(m_conf[1]));
    chk("ccnt0", 32'(cc0), m_cc[0]);  chk("ccnt1", 32'(cc1), m_cc[1]);
    chk("xcnt0", 32'(xc0), m_xc[0]);  chk("xcnt1", 32'(xc1), m_xc[1]);
  endtask

  task automatic step(input logic [N-1:0] so, input logic c, input logic cc, input bit full);
    for (int i = 0; i < N; i++) src_data[i*W +: W] = data[i];
    src_out = so; clr = c; conflict_clr = cc;
    @(posedge clk);
    #1;
    model(so, c, cc);
    if (full) check_all();
  endtask

  initial begin
    logic [N-1:0] so;
    for (int i = 0; i < N; i++) data[i] = $urandom;
    clr = 1'b1; conflict_clr = 1'b0; src_out = '0; src_data = '0;
    step(N'($urandom), 1, 0, 1);
    step(N'($urandom), 1, 0, 1);
    chk("reset_bus", bo0, 32'h0);
    chk("reset_xcnt", 32'(xc1), 32'h0);
    data[1] = 32'h00001111; data[2] = 32'h11110000;
    step(N'(1) << 1, 0, 0, 1);
    chk("single1_bus", bo0, 32'h00001111);
    chk("single1_sel", 32'(bs1), 32'd1);
    step(N'(1) << 2, 0, 0, 1);
    chk("single2_bus", bo1, 32'h11110000);
    chk("single2_xcnt", 32'(xc0), 32'd2);
    for (int i = 0; i < 3; i++) step('0, 0, 0, 1);
    chk("idle_hold", bo0, 32'h11110000);
    chk("idle_clear", bo1, 32'h0);
    chk("idle_valid", 32'(bv0), 32'd0);
    step('0, 1, 0, 1);
    so = N'('b100110);
    step(so, 0, 0, 1); chk("rr_a", 32'(bs1), 32'd1);
    step(so, 0, 0, 1); chk("rr_b", 32'(bs1), 32'd2); chk("fp_cnt2", 32'(cc0), 32'd2); chk("fp_sel", 32'(bs0), 32'd1);
    step(so, 0, 0, 1); chk("rr_c", 32'(bs1), 32'd5);
    step(so, 0, 0, 1); chk("rr_d", 32'(bs1), 32'd1); chk("fp_xcnt", 32'(xc0), 32'd0);
    step(so, 0, 1, 1); chk("clr_set_wins", 32'(cc1), 32'd1); chk("clr_set_flag", 32'(cf1), 32'd1);
    step('0, 0, 1, 1); chk("cclr_alone", 32'(cc0), 32'd0); chk("cclr_flag", 32'(cf0), 32'd0);
    step(N'(1) << 7, 0, 0, 1);
    step(so, 1, 0, 1); chk("clr_mid_bus", bo0, 32'h0); chk("clr_mid_valid", 32'(bv1), 32'd0);
    for (int i = 0; i < 300; i++) step(so | N'($urandom), 0, 0, 1);
    chk("ccnt_sat", 32'(cc0), 32'd255);
    for (int i = 0; i < 500; i++) begin
      for (int j = 0; j < N; j++) data[j] = $urandom;
      case ($urandom_range(0, 3))
        0: so = '0;
        1: so = N'(1) << $urandom_range(0, N - 1);
        2: so = (N'(1) << $urandom_range(0, N - 1)) | (N'(1) << $urandom_range(0, N - 1));
        default: so = N'($urandom);
      endcase
      step(so, ($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0), 1);
    end
    step('0, 1, 0, 1);
    for (int i = 0; i < 65535; i++) step(N'(1) << (i % N), 0, 0, (i % 4096) == 0);
    check_all();
    chk("xcnt_full", 32'(xc0), 32'd65535);
    step(N'(1) << 3, 0, 0, 1);
    chk("xcnt_wrap", 32'(xc1), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/bus_xfer_unit.md
Name: bus_xfer_unit

Overview:
- Parametrised, registered successor to the datapath source bus multiplexer.
- Selects one of NSRC source words from per-source out-enable strobes and drives it onto a registered bus with one cycle of latency.
- Adds idle hold, multi-driver conflict detection and a selectable arbitration mode (fixed priority or round-robin).
- Adds a count of transfers that completed without conflict.
- Sits between the register file, special registers and the ALU/MDR input latches.

Parameters:
- WIDTH, 32, bus word width in bits.
- NSRC, 24, number of source channels (R0..R15, HI, LO, Zhigh, Zlow, PC, MDR, InPort, C_sign_extended at default).
- HOLD_IDLE, 1, 1 = bus_out keeps its last value when no source is enabled; 0 = bus_out clears to 0.
- ARB_MODE, 0, 0 = fixed priority (lowest index wins); 1 = round-robin.
- SEL_W, $clog2(NSRC), width of the index outputs (derived localparam, not overridable).

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  synchronous active-high reset.
- src_data  in  NSRC*WIDTH  flattened source words; channel i occupies bits [i*WIDTH +: WIDTH].
- src_out  in  NSRC  per-source out-enable strobes (R0out..Cout ordering).
- conflict_clr  in  1  clears the sticky conflict flag.
- bus_out  out  WIDTH  registered bus value.
- bus_valid  out  1  high for one cycle per granted transfer.
- bus_sel  out  SEL_W  index of the granted source.
- conflict  out  1  sticky: set when more than one src_out bit was high.
- conflict_cnt  out  8  saturating count of conflict cycles.
- xfer_cnt  out  16  wrapping count of clean (single-driver) transfers.

Behaviour:
- Reset: on a clk edge with clr=1, all outputs go to 0 and the round-robin pointer rp goes to NSRC-1. clr overrides every other input, including in the middle of a burst.
- Latency: src_out/src_data sampled at edge k appear on bus_out, bus_sel and bus_valid after edge k. No combinational path from inputs to outputs.
- Idle (src_out == 0):
  - bus_valid <= 0.
  - bus_sel holds its value.
  - bus_out holds its value if HOLD_IDLE=1, else bus_out <= 0.
- Single driver (exactly one bit i set):
  - bus_out <= src_data[i], bus_sel <= i, bus_valid <= 1.
  - xfer_cnt <= xfer_cnt+1, wrapping from 0xFFFF to 0.
- Multi-driver (popcount > 1):
  - Grant selection:
    - ARB_MODE=0: grant the lowest set index.
    - ARB_MODE=1: grant the first set index searching rp+1, rp+2, … modulo NSRC.
  - Drive the granted source as in the single-driver case, bus_valid <= 1.
  - conflict <= 1; conflict_cnt <= conflict_cnt+1, saturating at 255.
  - xfer_cnt unchanged.
- Round-robin pointer: rp <= granted index on every grant, single or multi. rp is unchanged on idle. Unused when ARB_MODE=0.
- conflict_clr:
  - Clears conflict and conflict_cnt to 0 on the edge.
  - If a new conflict occurs in the same cycle, conflict <= 1 and conflict_cnt <= 1 (set wins).
- src_data bits of non-granted channels never affect any output. X on them must not propagate.
- Width rule: outputs are exactly WIDTH bits with no sign/zero extension. The block performs no arithmetic on data.
- Sizing: NSRC ≥ 2 and WIDTH ≥ 1 are required; an elaboration-time check flags violations.

Test Plan:
- Reset: hold clr=1 for 2 cycles with arbitrary src_out → bus_out=0, bus_valid=0, conflict=0, xfer_cnt=0. Assert clr during an active transfer → all outputs 0 after the next edge.
- Single-driver sequence: src[1]=0x00001111, src[2]=0x11110000. Assert src_out=bit1 for one cycle, then bit2 →
  - bus_out=0x00001111, bus_sel=1, bus_valid=1 one cycle after the first assertion;
  - then 0x11110000, bus_sel=2;
  - xfer_cnt=2, conflict=0.
- Idle hold: after the previous case, src_out=0 for 3 cycles →
  - HOLD_IDLE=1: bus_out stays 0x11110000, bus_valid=0;
  - HOLD_IDLE=0: bus_out=0.
- Fixed-priority conflict (ARB_MODE=0): src_out = bits 1|2|5 for 2 cycles → bus_sel=1 both cycles, conflict=1, conflict_cnt=2, xfer_cnt unchanged. Pulse conflict_clr alone → conflict=0, conflict_cnt=0.
- Round-robin (ARB_MODE=1): hold src_out = bits 1|2|5 for 4 cycles after reset → bus_sel sequence 1, 2, 5, 1. Then conflict_clr together with a continued conflict → conflict=1, conflict_cnt=1.
- Saturation/wrap:
  - 300 consecutive conflict cycles → conflict_cnt=255.
  - Preload via 65535 clean transfers, then one more → xfer_cnt=0.
